led_status_ctrl: RTL
====================

LED_STATUS_CTRL -- requirements
Module: led_status_ctrl

Interface
REQ-001 Parameter LED_W, default 16: LED vector width; SHALL be at least 12.
REQ-002 Parameter DIV, default 25_000_000: clocks per blink tick; SHALL be at least 2.
REQ-003 Parameter FLASH_TICKS, default 4: tick intervals in a state-change flash; SHALL be at least 1.
REQ-004 clk  input  1: single system clock; all registers SHALL update on its rising edge.
REQ-005 rst_n  input  1: reset, asynchronous and active-low.
REQ-006 state  input  2: game state; 0 START, 1 PLAY, 2 LOSE, 3 WIN.
REQ-007 mode  input  4: direction code; NONE 0000, UP 0010, DOWN 1000, LEFT 0001, RIGHT 0100, LEFTUP 0011, LEFTDOWN 0101, RIGHTUP 0110, RIGHTDOWN 0111.
REQ-008 led  output  LED_W: LED drive; SHALL decode from registers only, with no combinational path from any input.

Function
REQ-009 state and mode SHALL be sampled into state_q and mode_q every cycle, giving led a one-cycle latency from any input change.
REQ-010 Prescaler cnt: counts 0..DIV-1 and wraps to 0; a one-cycle tick SHALL pulse when cnt==DIV-1.
REQ-011 Blink phase bit: SHALL toggle on every tick.
REQ-012 Mode field led[3:0], decoded from mode_q:
- NONE -> 1111
- UP -> 1000
- DOWN -> 0100
- LEFT, LEFTUP, LEFTDOWN -> 0010
- RIGHT, RIGHTUP, RIGHTDOWN -> 0001
- any other code -> 0000 (no latch)
REQ-013 State field led[LED_W-1:LED_W-4], one-hot: bit LED_W-1-state_q is the lit bit.
- START, PLAY, WIN: lit bit steady.
- LOSE: lit bit equals blink phase.
REQ-014 Chase field led[LED_W-5:4]:
- Outside WIN: all zeros.
- In WIN: exactly one bit lit, at chase pointer ptr.
REQ-015 ptr movement: while state_q==WIN, ptr SHALL advance one bit toward the MSB on each tick, wrapping from LED_W-5 to 4.
REQ-016 ptr reload: ptr SHALL be set to 4 on the edge where state changes to WIN.
REQ-017 Change flag: chg = (state != state_q), evaluated each cycle.
REQ-018 FSM states: IDLE and FLASH.
- IDLE->FLASH on chg.
- FLASH->IDLE on the tick where fcnt==1.
REQ-019 On the edge where chg is true, in either FSM state:
- fcnt <= FLASH_TICKS
- flash_on <= 1
- cnt <= 0
- blink phase unchanged
REQ-020 In FLASH, on each tick: fcnt decrements and flash_on toggles.
REQ-021 In FLASH, led SHALL be all ones when flash_on==1 and all zeros when flash_on==0, overriding REQ-012 to REQ-014.
REQ-022 A state change during FLASH SHALL restart the flash per REQ-019; a mode change SHALL never start a flash.
REQ-023 After FLASH exits, led SHALL show normal fields from the next cycle, with blink phase and ptr continuing from their current values.

Reset
REQ-024 While rst_n is low, all registers SHALL hold their reset values, independent of clk:
- cnt=0, blink phase=0, ptr=4
- FSM=IDLE, fcnt=0, flash_on=0
- state_q=START, mode_q=NONE
REQ-025 Resulting reset value of led: 1 at bit LED_W-1 and at bits [3:0], 0 elsewhere (16'h800F at LED_W=16).
REQ-026 Reset asserted mid-flash or mid-chase SHALL abort the flash or chase immediately, with no output glitch sequence after release.
REQ-027 After rst_n rises with state=START held, no flash SHALL occur.

Verification
All scenarios use LED_W=16, DIV=4, FLASH_TICKS=2.
REQ-028 Reset: pulse rst_n low asynchronously between clock edges -> led=16'h800F immediately; after release, no flash while state=START.
REQ-029 Mode decode, state=START -> led[3:0], one cycle after each mode change:
- mode=0010 -> 1000
- mode=0110 -> 0001
- mode=0101 -> 0010
- mode=1111 -> 0000
- no flash occurs
REQ-030 Flash: state 0->1 with mode=NONE -> led response:
- 16'hFFFF for 4 clocks
- 16'h0000 for 4 clocks
- then steady 16'h400F
REQ-031 LOSE blink: state->2 and flash completes -> bit 13 toggles every 4 clocks; led[15:14,12:4]=0.
REQ-032 WIN chase: state->3 and flash completes -> ptr steps through bits 4, 5 ... 11, 4, one step per 4 clocks (ptr at 4 at flash exit); bit 12 steady 1.
REQ-033 Restart: state 1->2 mid-flash (third clock) -> led=16'hFFFF for 4 more clocks, then 16'h0000 for 4, then LOSE display.

Source files
------------

// File: rtl/led_status_ctrl.sv
// ---------------------------------------------------------------------------
// led_status_ctrl
// Drives a status LED bar for a small game.  The bar is split into three
// fields: a one-hot game-state field at the top, a chase field in the middle
// that runs a single lit bit while the game is won, and a direction field in
// the low nibble.  Every game-state change first flashes the whole bar on and
// off for FLASH_TICKS blink ticks before the normal fields are shown again.
//
// Parameters
//   LED_W       : LED vector width (at least 12)
//   DIV         : clocks per blink tick (at least 2)
//   FLASH_TICKS : tick intervals spent flashing after a state change (>= 1)
//
// Ports
//   clk    : system clock, all registers update on its rising edge
//   rst_n  : asynchronous active-low reset
//   state  : game state (0 START, 1 PLAY, 2 LOSE, 3 WIN)
//   mode   : direction code
//   led    : LED drive, decoded from registers only
// ---------------------------------------------------------------------------
module led_status_ctrl #(
   parameter int LED_W       = 16,
   parameter int DIV         = 25_000_000,
   parameter int FLASH_TICKS = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       state,
   input  logic [3:0]       mode,
   output logic [LED_W-1:0] led
);

   localparam int CW = $clog2(DIV);
   localparam int FW = $clog2(FLASH_TICKS + 1);
   localparam int PW = $clog2(LED_W);

   localparam logic [1:0] ST_START = 2'd0;
   localparam logic [1:0] ST_WIN   = 2'd3;

   typedef enum logic {
      IDLE  = 1'b0,
      FLASH = 1'b1
   } fsm_e;

   fsm_e            fsm_q;
   fsm_e            fsm_d;
   logic [1:0]      state_q;
   logic [3:0]      mode_q;
   logic [CW-1:0]   cnt;
   logic            blink;
   logic [PW-1:0]   ptr;
   logic [FW-1:0]   fcnt;
   logic [FW-1:0]   fcnt_d;
   logic            flash_on;
   logic            flash_on_d;
   logic            chg;
   logic            tick;

   assign chg  = (state != state_q);
   assign tick = (cnt == CW'(DIV - 1));

   // Input sampling: the LED decode only ever looks at these copies, so the
   // outputs trail the inputs by exactly one clock and have no input path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_START;
         mode_q  <= 4'b0000;
      end else begin
         state_q <= state;
         mode_q  <= mode;
      end
   end

   // Prescaler, blink phase and chase pointer.  A state change restarts the
   // prescaler so the flash always gets full-length tick intervals; the blink
   // phase is left alone on that edge.  The pointer is frozen while flashing
   // so the chase starts at bit 4 once the flash ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         blink <= 1'b0;
         ptr   <= PW'(4);
      end else begin
         if (chg || tick) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
         if (tick && !chg) begin
            blink <= ~blink;
         end
         if (chg && (state == ST_WIN)) begin
            ptr <= PW'(4);
         end else if (!chg && tick && (fsm_q == IDLE) && (state_q == ST_WIN)) begin
            ptr <= (ptr == PW'(LED_W - 5)) ? PW'(4) : ptr + PW'(1);
         end
      end
   end

   // Flash FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q    <= IDLE;
         fcnt     <= '0;
         flash_on <= 1'b0;
      end else begin
         fsm_q    <= fsm_d;
         fcnt     <= fcnt_d;
         flash_on <= flash_on_d;
      end
   end

   // Flash FSM next state.  A state change (re)arms the flash from either
   // state; in FLASH each tick counts down and toggles the bar, and the tick
   // that sees the last interval returns to IDLE.
   always_comb begin
      fsm_d      = fsm_q;
      fcnt_d     = fcnt;
      flash_on_d = flash_on;
      if (chg) begin
         fsm_d      = FLASH;
         fcnt_d     = FW'(FLASH_TICKS);
         flash_on_d = 1'b1;
      end else if ((fsm_q == FLASH) && tick) begin
         fcnt_d     = fcnt - FW'(1);
         flash_on_d = ~flash_on;
         if (fcnt == FW'(1)) begin
            fsm_d = IDLE;
         end
      end
   end

   // LED decode.  The flash overrides everything; otherwise the three fields
   // are assembled from the sampled state, mode, blink phase and pointer.
   always_comb begin
      led = '0;
      if (fsm_q == FLASH) begin
         led = flash_on ? '1 : '0;
      end else begin
         case (mode_q)
            4'b0000: led[3:0] = 4'b1111;
            4'b0010: led[3:0] = 4'b1000;
            4'b1000: led[3:0] = 4'b0100;
            4'b0001,
            4'b0011,
            4'b0101: led[3:0] = 4'b0010;
            4'b0100,
            4'b0110,
            4'b0111: led[3:0] = 4'b0001;
            default: led[3:0] = 4'b0000;
         endcase
         case (state_q)
            2'd0:    led[LED_W-1] = 1'b1;
            2'd1:    led[LED_W-2] = 1'b1;
            2'd2:    led[LED_W-3] = blink;
            default: led[LED_W-4] = 1'b1;
         endcase
         if (state_q == ST_WIN) begin
            for (int i = 4; i <= LED_W - 5; i++) begin
               led[i] = (ptr == PW'(i));
            end
         end
      end
   end

endmodule
